// File: rtl/regfile_pkg.sv
// Shared Argon register-file definitions: bus command encoding, sequencer request ops
// and the default data/index widths used by the register file and its sequencer.
package regfile_pkg;

   localparam int WORD_WIDTH  = 16;
   localparam int INDEX_WIDTH = 3;

   // COM_NONE falls into the register file's default decode, so it is a true no-op on the bus
   typedef enum logic [2:0] {
      COM_NONE     = 3'd0,
      COM_LATCHSEL = 3'd1,
      COM_LATCHC   = 3'd2,
      COM_ALU_WE   = 3'd3,
      COM_READA    = 3'd4,
      COM_READB    = 3'd5,
      COM_READF    = 3'd6
   } command_t;

   typedef enum logic [2:0] {
      OP_ALU   = 3'd0,
      OP_LOADI = 3'd1,
      OP_READA = 3'd2,
      OP_READB = 3'd3,
      OP_READF = 3'd4
   } seq_op_t;

endpackage

// File: rtl/argon_regfile_sequencer.sv
// Turns one register-file request into the ordered bus stream COM_LATCHSEL + one data
// command, with a bounded wait on read data and a valid/ready response channel.
module argon_regfile_sequencer
   import regfile_pkg::*;
#(
   parameter int WORD_WIDTH   = 16,
   parameter int INDEX_WIDTH  = 3,
   parameter int READ_TIMEOUT = 4
) (
   input  logic                   i_Clk,
   input  logic                   i_Reset,
   input  logic                   i_req_valid,
   output logic                   o_req_ready,
   input  seq_op_t                i_req_op,
   input  logic [INDEX_WIDTH-1:0] i_req_sel_a,
   input  logic [INDEX_WIDTH-1:0] i_req_sel_b,
   input  logic [INDEX_WIDTH-1:0] i_req_sel_c,
   input  logic [WORD_WIDTH-1:0]  i_req_imm,
   output logic                   o_rsp_valid,
   input  logic                   i_rsp_ready,
   output logic [WORD_WIDTH-1:0]  o_rsp_data,
   output logic                   o_rsp_error,
   output command_t               o_bus_command,
   output logic [WORD_WIDTH-1:0]  o_bus_data,
   output logic                   o_bus_valid,
   input  logic [WORD_WIDTH-1:0]  i_bus_data,
   input  logic                   i_bus_valid
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SELECT = 2'd1,
      S_EXEC   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam int                   CNT_WIDTH = $clog2(READ_TIMEOUT + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(READ_TIMEOUT - 1);

   state_t                 state_q, state_d;
   seq_op_t                op_q, op_d;
   logic [INDEX_WIDTH-1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d, sel_c_q, sel_c_d;
   logic [WORD_WIDTH-1:0]  imm_q, imm_d;
   logic [WORD_WIDTH-1:0]  rsp_data_q, rsp_data_d;
   logic                   rsp_error_q, rsp_error_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

   command_t               bus_command_s, read_cmd_s;
   logic [WORD_WIDTH-1:0]  bus_data_s, sel_word_s;
   logic                   bus_valid_s;

   // State, captured request fields, response holding registers and read wait counter
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q     <= S_IDLE;
         op_q        <= OP_ALU;
         sel_a_q     <= '0;
         sel_b_q     <= '0;
         sel_c_q     <= '0;
         imm_q       <= '0;
         rsp_data_q  <= '0;
         rsp_error_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         sel_a_q     <= sel_a_d;
         sel_b_q     <= sel_b_d;
         sel_c_q     <= sel_c_d;
         imm_q       <= imm_d;
         rsp_data_q  <= rsp_data_d;
         rsp_error_q <= rsp_error_d;
         cnt_q       <= cnt_d;
      end
   end

   // Next-state logic plus Moore decode of the bus lines from the current state
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      sel_a_d       = sel_a_q;
      sel_b_d       = sel_b_q;
      sel_c_d       = sel_c_q;
      imm_d         = imm_q;
      rsp_data_d    = rsp_data_q;
      rsp_error_d   = rsp_error_q;
      cnt_d         = cnt_q;
      bus_command_s = COM_NONE;
      bus_data_s    = '0;
      bus_valid_s   = 1'b0;
      sel_word_s    = '0;
      sel_word_s[3*INDEX_WIDTH-1:0] = {sel_c_q, sel_b_q, sel_a_q};

      case (op_q)
         OP_READB: read_cmd_s = COM_READB;
         OP_READF: read_cmd_s = COM_READF;
         default:  read_cmd_s = COM_READA;
      endcase

      case (state_q)
         S_IDLE: begin
            if (i_req_valid) begin
               op_d        = i_req_op;
               sel_a_d     = i_req_sel_a;
               sel_b_d     = i_req_sel_b;
               sel_c_d     = i_req_sel_c;
               imm_d       = i_req_imm;
               rsp_data_d  = '0;
               rsp_error_d = 1'b0;
               cnt_d       = '0;
               // the flag register needs no operand selection
               state_d     = (i_req_op == OP_READF) ? S_EXEC : S_SELECT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SELECT: begin
            bus_command_s = COM_LATCHSEL;
            bus_valid_s   = 1'b1;
            bus_data_s    = sel_word_s;
            cnt_d         = '0;
            state_d       = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_DONE;
            case (op_q)
               OP_ALU: bus_command_s = COM_ALU_WE;
               OP_LOADI: begin
                  // r0 is hard-wired, so a load to it is refused rather than issued
                  if (sel_c_q == '0) begin
                     rsp_error_d = 1'b1;
                  end else begin
                     bus_command_s = COM_LATCHC;
                     bus_valid_s   = 1'b1;
                     bus_data_s    = imm_q;
                  end
               end
               OP_READA, OP_READB, OP_READF: begin
                  bus_command_s = read_cmd_s;
                  if (i_bus_valid) begin
                     rsp_data_d = i_bus_data;
                  end else if (cnt_q == CNT_LAST) begin
                     rsp_error_d = 1'b1;
                  end else begin
                     cnt_d   = cnt_q + CNT_WIDTH'(1);
                     state_d = S_EXEC;
                  end
               end
               default: rsp_error_d = 1'b1;
            endcase
         end
         S_DONE: begin
            if (i_rsp_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_req_ready   = (state_q == S_IDLE);
   assign o_rsp_valid   = (state_q == S_DONE);
   assign o_rsp_data    = rsp_data_q;
   assign o_rsp_error   = rsp_error_q;
   assign o_bus_command = bus_command_s;
   assign o_bus_data    = bus_data_s;
   assign o_bus_valid   = bus_valid_s;

endmodule
